pc_stack_unit: RTL
==================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter PC_W, default 8, PC width in bits.
REQ-002 Parameter PC_INCR, default 1, sequential increment added per advance.
REQ-003 Parameter DIV_CNT, default 4, clk cycles per PC tick (DIV_CNT >= 1).
REQ-004 Parameter STACK_DEPTH, default 4, return-stack entries (power of two, >= 2).
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 op  input  3  operation code: NEXT, JUMP, BRANCH, CALL, RET, HOLD.
REQ-008 target  input  PC_W  absolute address for JUMP and CALL.
REQ-009 offset  input  PC_W  two's-complement displacement for BRANCH.
REQ-010 cond  input  1  branch-taken qualifier for BRANCH.
REQ-011 pc  output  PC_W  current program counter.
REQ-012 tick  output  1  one-cycle pulse marking the cycle in which pc updates.
REQ-013 stack_empty / stack_full  output  1 each  return-stack occupancy flags.
REQ-014 err  output  1  sticky fault flag for stack overflow or underflow.
REQ-015 addr_led  output  PC_W  mirror of pc for board LEDs.

Function
REQ-016 Internal divider counts 0..DIV_CNT-1 and asserts tick when the count is DIV_CNT-1. With DIV_CNT=1, tick is high every cycle. No derived clock is generated.
REQ-017 op, target, offset and cond are sampled only in the tick cycle. pc changes on the clk edge that ends the tick cycle. Inputs are ignored in all other cycles.
REQ-018 NEXT: pc <= pc + PC_INCR, modulo 2^PC_W.
REQ-019 JUMP: pc <= target.
REQ-020 BRANCH with cond=1: pc <= pc + offset, modulo 2^PC_W. BRANCH with cond=0 behaves as NEXT.
REQ-021 CALL when not full: push (pc + PC_INCR) mod 2^PC_W, then pc <= target.
REQ-022 RET when not empty: pop, and pc <= popped value.
REQ-023 HOLD: pc unchanged; the divider keeps running.
REQ-024 Unused op codes behave as HOLD.
REQ-025 CALL when stack_full: no push, pc unchanged, err <= 1.
REQ-026 RET when stack_empty: no pop, pc unchanged, err <= 1.
REQ-027 err stays set until reset. Later operations proceed normally while err is set.
REQ-028 Stack is LIFO, at most one push or pop per tick. stack_full is high when occupancy = STACK_DEPTH; stack_empty is high when occupancy = 0.
REQ-029 Flags and pc are registered and reflect the state after the update, with no combinational path from op to any output.
REQ-030 addr_led equals pc in every cycle.

Reset
REQ-031 While rst=0 at a clk edge: pc=0, divider count=0, tick=0, stack occupancy=0, stack_empty=1, stack_full=0, err=0.
REQ-032 Reset takes priority over any op, including in a tick cycle and during a CALL/RET. Stack contents need not be cleared; only the pointer is cleared.
REQ-033 After rst returns to 1, the first tick occurs DIV_CNT cycles later.

Structure
REQ-034 Op-code encodings are defined in shared package pc_pkg and referenced by name: NEXT=0, JUMP=1, BRANCH=2, CALL=3, RET=4, HOLD=5.
REQ-035 The return stack is the sub-module pc_ret_stack, with push, pop, din, dout, full and empty ports, parametrised by PC_W and STACK_DEPTH.
REQ-036 The divider and the PC next-state logic live in pc_stack_unit.

Verification
REQ-037 Wrap: PC_W=4, PC_INCR=6, DIV_CNT=1, NEXT from reset -> pc sequence 0,6,12,2,8.
REQ-038 Divider: DIV_CNT=4, NEXT held -> tick every 4th cycle, and pc steps 0->1 only after the first tick.
REQ-039 Branch: pc=10, BRANCH offset=8'hFD cond=1 -> pc=7. Same stimulus with cond=0 -> pc=11.
REQ-040 Call/return: pc=3, CALL target=40 -> pc=40, stack_empty=0. Then RET -> pc=4, stack_empty=1.
REQ-041 Overflow/underflow: 5 CALLs with STACK_DEPTH=4 -> fifth leaves pc unchanged and sets err=1. Reset, then RET -> pc=0, err=1.
REQ-042 Reset mid-op: rst=0 in a CALL tick cycle -> pc=0, stack_empty=1, err=0; the next tick follows DIV_CNT cycles after rst is released.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / return-stack unit:
// operation encodings and a width helper used by the divider.
package pc_pkg;

    typedef enum logic [2:0] {
        NEXT   = 3'd0,
        JUMP   = 3'd1,
        BRANCH = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4,
        HOLD   = 3'd5
    } pc_op_e;

    localparam int OP_W = 3;

    // Counter width that stays legal (>= 1 bit) for a modulus of 1.
    function automatic int cnt_width(input int modulus);
        return (modulus <= 1) ? 1 : $clog2(modulus);
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO return-address stack: one push or pop per cycle, occupancy flags
// derived from the registered pointer, top entry readable without latency.
module pc_ret_stack #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty
);

    localparam int PTR_W = $clog2(STACK_DEPTH);

    logic [PTR_W:0]   count_reg;
    logic [PC_W-1:0]  mem_reg [STACK_DEPTH];
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;
    logic             full_int;
    logic             empty_int;
    logic             do_push;
    logic             do_pop;

    assign wr_idx    = count_reg[PTR_W-1:0];
    assign top_idx   = wr_idx - PTR_W'(1);
    assign full_int  = (count_reg == (PTR_W+1)'(STACK_DEPTH));
    assign empty_int = (count_reg == '0);
    assign do_push   = rst && push && !full_int;
    assign do_pop    = rst && pop && !empty_int;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (do_push) begin
            count_reg <= count_reg + 1'b1;
        end else if (do_pop) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // Contents are never cleared; only the pointer decides what is valid.
    for (genvar gi = 0; gi < STACK_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_idx == PTR_W'(gi))) begin
                mem_reg[gi] <= din;
            end
        end
    end

    // The popped address must be usable in the same tick, so the top is read asynchronously.
    assign dout  = mem_reg[top_idx];
    assign full  = full_int;
    assign empty = empty_int;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with clock-enable divider and a call/return stack.
// Operations are sampled only in the tick cycle; all outputs are registered state.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int PC_INCR     = 1,
    parameter int DIV_CNT     = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic [PC_W-1:0] target,
    input  logic [PC_W-1:0] offset,
    input  logic            cond,
    output logic [PC_W-1:0] pc,
    output logic            tick,
    output logic            stack_empty,
    output logic            stack_full,
    output logic            err,
    output logic [PC_W-1:0] addr_led
);

    localparam int               CNT_W    = cnt_width(DIV_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CNT - 1);
    localparam logic [PC_W-1:0]  INCR     = PC_W'(PC_INCR);

    logic [CNT_W-1:0] cnt_reg;
    logic             tick_reg;
    logic [PC_W-1:0]  pc_reg;
    logic [PC_W-1:0]  pc_next;
    logic             err_reg;
    logic             err_next;
    logic [PC_W-1:0]  seq_pc;
    logic             push;
    logic             pop;
    logic [PC_W-1:0]  stk_dout;
    logic             stk_full;
    logic             stk_empty;

    assign seq_pc = pc_reg + INCR;

    // tick is registered off the terminal count so it is low in reset even
    // when DIV_CNT is 1, and the first tick lands DIV_CNT edges after release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg  <= '0;
            tick_reg <= 1'b0;
            pc_reg   <= '0;
            err_reg  <= 1'b0;
        end else begin
            cnt_reg  <= (cnt_reg == CNT_LAST) ? '0 : cnt_reg + 1'b1;
            tick_reg <= (cnt_reg == CNT_LAST);
            if (tick_reg) begin
                pc_reg  <= pc_next;
                err_reg <= err_next;
            end
        end
    end

    always_comb begin
        pc_next  = pc_reg;
        err_next = err_reg;
        push     = 1'b0;
        pop      = 1'b0;
        case (op)
            NEXT:   pc_next = seq_pc;
            JUMP:   pc_next = target;
            BRANCH: pc_next = cond ? (pc_reg + offset) : seq_pc;
            CALL: begin
                if (stk_full) begin
                    err_next = 1'b1;
                end else begin
                    push    = tick_reg;
                    pc_next = target;
                end
            end
            RET: begin
                if (stk_empty) begin
                    err_next = 1'b1;
                end else begin
                    pop     = tick_reg;
                    pc_next = stk_dout;
                end
            end
            default: ;
        endcase
    end

    pc_ret_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (seq_pc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign pc          = pc_reg;
    assign addr_led    = pc_reg;
    assign tick        = tick_reg;
    assign err         = err_reg;
    assign stack_empty = stk_empty;
    assign stack_full  = stk_full;

endmodule
